bram_fifo_ctrl: RTL

FIFO controller that turns the team's dual-port BRAM into a first-word-fall-through stream buffer with valid/ready handshakes on both sides. Port A of the BRAM serves as the write port and port B as the read port. The BRAM read has one cycle of latency, which a 2-entry output buffer hides. The block sits directly upstream of the BRAM and drives all of its ports; the datapath stages around it see only the stream interfaces.

---
 rtl/bram_fifo_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/bram_fifo_ctrl.sv
// First-word-fall-through stream FIFO built around a dual-port BRAM (A = write, B = read).
// Optional almost_full output is enabled with the BRAM_FIFO_ALMOST_EN macro.
module bram_fifo_ctrl #(
  parameter int FIFO_DEPTH = 512,
  parameter int MEM_WIDTH  = $clog2(FIFO_DEPTH),
  parameter int DATA_WIDTH = 16
`ifdef BRAM_FIFO_ALMOST_EN
  , parameter int ALMOST_FULL_THRESH = FIFO_DEPTH - 4
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [MEM_WIDTH+1:0]  level,
`ifdef BRAM_FIFO_ALMOST_EN
  output logic                  almost_full,
`endif
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [MEM_WIDTH-1:0]  ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dia,
  output logic                  ram_enb,
  output logic [MEM_WIDTH-1:0]  ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_dob
);

  typedef logic [MEM_WIDTH-1:0]  ptr_t;
  typedef logic [MEM_WIDTH:0]    cnt_t;
  typedef logic [MEM_WIDTH+1:0]  lvl_t;
  typedef logic [DATA_WIDTH-1:0] dat_t;

  localparam ptr_t PTR_ONE = ptr_t'(1);
  localparam cnt_t CNT_ONE = cnt_t'(1);
  localparam lvl_t LVL_ONE = lvl_t'(1);
  localparam cnt_t DEPTH_C = cnt_t'(FIFO_DEPTH);

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t mem_count_q, mem_count_d;
  lvl_t level_q, level_d;
  logic [1:0] occ_q, occ_d;
  logic inflight_q;
  logic s_ready_q, s_ready_d;
  dat_t buf0_q, buf0_d;
  dat_t buf1_q, buf1_d;

  logic push, pop, issue;
  logic [2:0] pend;

  always_comb begin
    push = s_valid && s_ready_q && !rst;
    pop  = (occ_q != 2'd0) && m_ready;
    pend = {1'b0, occ_q} + {2'b00, inflight_q};
    // Issue only if the word will have a free output slot when it lands.
    issue = !rst && (mem_count_q != '0) && (pend < (3'd2 + {2'b00, pop}));

    wr_ptr_d = push  ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = issue ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    mem_count_d = mem_count_q;
    case ({push, issue})
      2'b10:   mem_count_d = mem_count_q + CNT_ONE;
      2'b01:   mem_count_d = mem_count_q - CNT_ONE;
      default: mem_count_d = mem_count_q;
    endcase

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    s_ready_d = (mem_count_d < DEPTH_C);
    occ_d     = occ_q + {1'b0, inflight_q} - {1'b0, pop};

    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (pop) begin
      if (occ_q == 2'd2) begin
        buf0_d = buf1_q;
        if (inflight_q) buf1_d = ram_dob;
      end else if (inflight_q) begin
        buf0_d = ram_dob;
      end
    end else if (inflight_q) begin
      if (occ_q == 2'd0) buf0_d = ram_dob;
      else               buf1_d = ram_dob;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      level_q     <= '0;
      occ_q       <= '0;
      inflight_q  <= 1'b0;
      s_ready_q   <= 1'b0;
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      level_q     <= level_d;
      occ_q       <= occ_d;
      inflight_q  <= issue;
      s_ready_q   <= s_ready_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end

`ifdef BRAM_FIFO_ALMOST_EN
  localparam cnt_t THRESH_C = cnt_t'(ALMOST_FULL_THRESH);
  logic almost_full_q;

  always_ff @(posedge clk) begin
    if (rst) almost_full_q <= 1'b0;
    else     almost_full_q <= (mem_count_d >= THRESH_C);
  end

  assign almost_full = almost_full_q;
`endif

  assign s_ready   = s_ready_q;
  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = buf0_q;
  assign level     = level_q;
  assign ram_ena   = push;
  assign ram_wea   = push;
  assign ram_addra = wr_ptr_q;
  assign ram_dia   = s_data;
  assign ram_enb   = issue;
  assign ram_addrb = rd_ptr_q;

endmodule
